// File: rtl/sensor_input_conditioner.sv
// ---------------------------------------------------------------------------
// sensor_input_conditioner
//
// Front end for the irrigation controller. It takes six raw field-sensor
// switches, synchronises each one and debounces it, and presents glitch-free
// levels to the downstream logic. It also flags inconsistent water-level
// combinations and strobes when any debounced level changes.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive disagreeing cycles before a
//                     stable level flips (1..65535)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   i_clock                  system clock, rising edge
//   i_reset                  synchronous, active-high reset
//   i_raw_*_water_level      asynchronous float switches (1 = water present)
//   i_raw_earth_humidity     asynchronous sensor contact, active high
//   i_raw_air_humidity       asynchronous sensor contact, active high
//   i_raw_low_temperature    asynchronous sensor contact, active high
//   i_clear_fault            single-cycle request to clear a latched fault
//   o_*                      debounced stable levels
//   o_sensors_changed        one-cycle strobe when any stable level changed
//   o_water_fault            water-level inconsistency flag
//
// Build option
//   SENSOR_FAULT_LATCH_EN : when defined, o_water_fault is sticky and is
//                           cleared by i_clear_fault once the conflict is gone.
//                           When undefined, o_water_fault follows the conflict
//                           one cycle late and i_clear_fault is ignored.
// ---------------------------------------------------------------------------
module sensor_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw_low_water_level,
    input  logic i_raw_mid_water_level,
    input  logic i_raw_high_water_level,
    input  logic i_raw_earth_humidity,
    input  logic i_raw_air_humidity,
    input  logic i_raw_low_temperature,
    input  logic i_clear_fault,
    output logic o_low_water_level,
    output logic o_mid_water_level,
    output logic o_high_water_level,
    output logic o_earth_humidity,
    output logic o_air_humidity,
    output logic o_low_temperature,
    output logic o_sensors_changed,
    output logic o_water_fault
);

    localparam int unsigned N_CH     = 6;
    localparam int unsigned CH_LOW   = 0;
    localparam int unsigned CH_MID   = 1;
    localparam int unsigned CH_HIGH  = 2;
    localparam int unsigned CH_EARTH = 3;
    localparam int unsigned CH_AIR   = 4;
    localparam int unsigned CH_TEMP  = 5;

    // Terminal count: the mismatch that reaches this value commits the flip.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0] w_raw;
    logic [N_CH-1:0] r_s1;
    logic [N_CH-1:0] r_s2;
    logic [N_CH-1:0] r_stable;
    logic [N_CH-1:0] w_flip;
    logic            w_conflict;
    logic            r_changed;
    logic            r_fault;

    assign w_raw[CH_LOW]   = i_raw_low_water_level;
    assign w_raw[CH_MID]   = i_raw_mid_water_level;
    assign w_raw[CH_HIGH]  = i_raw_high_water_level;
    assign w_raw[CH_EARTH] = i_raw_earth_humidity;
    assign w_raw[CH_AIR]   = i_raw_air_humidity;
    assign w_raw[CH_TEMP]  = i_raw_low_temperature;

    // Two-flop synchroniser for all asynchronous inputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-channel debounce counter; any agreement restarts the count.
    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;

            assign w_flip[g] = (r_s2[g] != r_stable[g]) && (r_cnt == LAST_CNT);

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_cnt <= '0;
                end else if ((r_s2[g] == r_stable[g]) || (r_cnt == LAST_CNT)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Stable levels and change strobe; the strobe lands on the same edge as the flip.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_stable  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_stable  <= r_stable ^ w_flip;
            r_changed <= |w_flip;
        end
    end

    // A higher float cannot be wet while a lower one is dry.
    assign w_conflict = (r_stable[CH_HIGH] & ~r_stable[CH_MID]) |
                        (r_stable[CH_MID]  & ~r_stable[CH_LOW]);

`ifdef SENSOR_FAULT_LATCH_EN
    // Sticky fault: a live conflict wins over a clear request.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fault <= 1'b0;
        end else if (w_conflict) begin
            r_fault <= 1'b1;
        end else if (i_clear_fault) begin
            r_fault <= 1'b0;
        end
    end
`else
    logic w_unused_clear_fault;
    assign w_unused_clear_fault = i_clear_fault;

    // Fault follows the conflict with one cycle of lag.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_conflict;
        end
    end
`endif

    assign o_low_water_level  = r_stable[CH_LOW];
    assign o_mid_water_level  = r_stable[CH_MID];
    assign o_high_water_level = r_stable[CH_HIGH];
    assign o_earth_humidity   = r_stable[CH_EARTH];
    assign o_air_humidity     = r_stable[CH_AIR];
    assign o_low_temperature  = r_stable[CH_TEMP];
    assign o_sensors_changed  = r_changed;
    assign o_water_fault      = r_fault;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_sensor_input_conditioner
//
// Self-checking bench for sensor_input_conditioner with DEBOUNCE_CYCLES=4.
// Channel bit order in the packed vectors: 0 low, 1 mid, 2 high, 3 earth,
// 4 air, 5 low temperature.
// ---------------------------------------------------------------------------
module tb_sensor_input_conditioner;

    localparam int unsigned D = 4;

`ifdef SENSOR_FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [5:0] raw = '0;

    logic o_low, o_mid, o_high, o_earth, o_air, o_temp, o_chg, o_fault;
    logic [5:0] dut_st;
    assign dut_st = {o_temp, o_air, o_earth, o_high, o_mid, o_low};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .i_clock               (clk),
        .i_reset               (rst),
        .i_raw_low_water_level (raw[0]),
        .i_raw_mid_water_level (raw[1]),
        .i_raw_high_water_level(raw[2]),
        .i_raw_earth_humidity  (raw[3]),
        .i_raw_air_humidity    (raw[4]),
        .i_raw_low_temperature (raw[5]),
        .i_clear_fault         (clr),
        .o_low_water_level     (o_low),
        .o_mid_water_level     (o_mid),
        .o_high_water_level    (o_high),
        .o_earth_humidity      (o_earth),
        .o_air_humidity        (o_air),
        .o_low_temperature     (o_temp),
        .o_sensors_changed     (o_chg),
        .o_water_fault         (o_fault)
    );

    // ---------------- reference model ----------------
    // A level flips once the synchronised input has disagreed with it for D
    // consecutive samples taken since the last reset or flip.
    logic [5:0] m_s1 = '0, m_s2 = '0, m_st = '0;
    logic       m_chg = 1'b0, m_fault = 1'b0;
    logic [5:0] hist[$];
    int         since[6];

    function automatic logic conflict_of(input logic [5:0] s);
        return (s[2] && !s[1]) || (s[1] && !s[0]);
    endfunction

    task automatic model_edge();
        logic [5:0] old_st, new_st;
        logic       cf;
        bit         all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_chg = 1'b0; m_fault = 1'b0;
            hist.delete();
            for (int c = 0; c < 6; c++) since[c] = 0;
        end else begin
            old_st = m_st;
            new_st = m_st;
            cf     = conflict_of(old_st);
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            for (int c = 0; c < 6; c++) begin
                since[c]++;
                all_diff = (since[c] >= D) && (hist.size() == D);
                for (int j = 0; j < hist.size(); j++)
                    if (hist[j][c] == old_st[c]) all_diff = 1'b0;
                if (all_diff) begin
                    new_st[c] = ~old_st[c];
                    since[c]  = 0;
                end
            end
            m_chg   = (new_st != old_st);
            m_fault = LATCH ? (cf || (m_fault && !clr)) : cf;
            m_st    = new_st;
            m_s2    = m_s1;
            m_s1    = raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       clr;
        logic [5:0] raw;
        int         cyc;
        logic [5:0] exp_st;
        logic       exp_chg;
        logic       exp_fault;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic r, input logic c, input logic [5:0] w,
                                input int n, input logic [5:0] s, input logic ch,
                                input logic f);
        vec_t v;
        v.rst = r; v.clr = c; v.raw = w; v.cyc = n;
        v.exp_st = s; v.exp_chg = ch; v.exp_fault = f;
        return v;
    endfunction

    initial begin
        // Reset with all inputs high, then debounce to all-high.
        tbl[0]  = mk(1, 0, 6'h3F, 2, 6'h00, 0, 0);
        tbl[1]  = mk(0, 0, 6'h3F, 5, 6'h00, 0, 0);
        tbl[2]  = mk(0, 0, 6'h3F, 1, 6'h3F, 1, 0);
        tbl[3]  = mk(0, 0, 6'h3F, 1, 6'h3F, 0, 0);
        // Drop mid: high&~mid conflict, fault one cycle after the stable change.
        tbl[4]  = mk(0, 0, 6'h3D, 5, 6'h3F, 0, 0);
        tbl[5]  = mk(0, 0, 6'h3D, 1, 6'h3D, 1, 0);
        tbl[6]  = mk(0, 0, 6'h3D, 1, 6'h3D, 0, 1);
        // Restore mid: fault clears one cycle later unless latched.
        tbl[7]  = mk(0, 0, 6'h3F, 6, 6'h3F, 1, 1);
        tbl[8]  = mk(0, 0, 6'h3F, 1, 6'h3F, 0, LATCH);
        tbl[9]  = mk(0, 1, 6'h3F, 1, 6'h3F, 0, 0);
        // Clear during an active conflict must not clear.
        tbl[10] = mk(0, 0, 6'h3D, 6, 6'h3D, 1, 0);
        tbl[11] = mk(0, 1, 6'h3D, 1, 6'h3D, 0, 1);
        tbl[12] = mk(0, 0, 6'h3F, 6, 6'h3F, 1, 1);
        tbl[13] = mk(0, 0, 6'h3F, 1, 6'h3F, 0, LATCH);
        tbl[14] = mk(0, 1, 6'h3F, 1, 6'h3F, 0, 0);

        // Table phase
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; clr = tbl[i].clr; raw = tbl[i].raw;
            for (int k = 0; k < tbl[i].cyc; k++) tick();
            check($sformatf("vec%0d", i), {o_fault, o_chg, dut_st},
                  {tbl[i].exp_fault, tbl[i].exp_chg, tbl[i].exp_st});
        end
        clr = 1'b0;

        // Return to a quiet all-low state
        rst = 1'b1; raw = '0;
        tick(); tick();
        check("reset_again", {o_fault, o_chg, dut_st}, 8'h00);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Clean transition: earth sampled at edge k, visible at edge k+5 only
        raw[3] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("clean_early", {7'd0, o_earth}, 8'h00);
        tick();
        check("clean_rise", {6'd0, o_chg, o_earth}, 8'h03);
        tick();
        check("clean_strobe_end", {6'd0, o_chg, o_earth}, 8'h01);

        // Glitch rejection: air high for 3 samples never reaches the output
        raw[4] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        raw[4] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("glitch", {6'd0, o_chg, o_air}, 8'h00);
        end

        // Restart rule: 3 high, 1 low, then high; rise only 5 edges after the restart
        raw[5] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        raw[5] = 1'b0;
        tick();
        raw[5] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("restart_hold", {7'd0, o_temp}, 8'h00);
        end
        tick();
        check("restart_rise", {6'd0, o_chg, o_temp}, 8'h03);

        // Reset mid-debounce discards the pending count
        raw[3] = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick();
        check("mid_reset", {o_fault, o_chg, dut_st}, 8'h00);
        rst = 1'b0; raw = 6'h08;
        for (int k = 0; k < 5; k++) tick();
        check("mid_reset_hold", {7'd0, o_earth}, 8'h00);
        tick();
        check("mid_reset_rise", {6'd0, o_chg, o_earth}, 8'h03);

        // Random phase against the reference model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < 6; c++)
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            tick();
            check("random", {o_fault, o_chg, dut_st}, {m_fault, m_chg, m_st});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_input_conditioner.md
# sensor_input_conditioner

Upstream front end for the irrigation controller. Synchronises and debounces the six raw field-sensor switches: three water levels, earth humidity, air humidity and low temperature. It presents glitch-free levels to the water-checking, irrigation and display logic. It also flags inconsistent water-level combinations and pulses a change strobe, so downstream display or counter logic can refresh.

## Interface
- DEBOUNCE_CYCLES, default 1000: consecutive mismatching clock cycles required before a stable output flips; legal range 1..65535.
- CNT_W, default 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_low_water_level, raw_mid_water_level, raw_high_water_level  input  1 each  asynchronous float switches; 1 = water at or above that level.
- raw_earth_humidity, raw_air_humidity, raw_low_temperature  input  1 each  asynchronous sensor contacts, active high.
- clear_fault  input  1  synchronous single-cycle request to clear a latched fault; only used with the configuration macro.
- low_water_level, mid_water_level, high_water_level, earth_humidity, air_humidity, low_temperature  output  1 each  debounced stable levels.
- sensors_changed  output  1  one-cycle strobe; any stable output changed this cycle.
- water_fault  output  1  water-level inconsistency flag.

## Operation
- Each input has its own channel: a two-flop synchroniser (s1, s2), a CNT_W-bit counter and a stable register.
- On each edge where s2 differs from stable:
  - if the counter equals DEBOUNCE_CYCLES-1, stable takes the s2 value and the counter returns to 0;
  - otherwise the counter increments.
- On each edge where s2 equals stable, the counter clears to 0. Any single-cycle agreement restarts the count; there is no partial credit.
- Channels are fully independent. Several may flip on the same edge.
- sensors_changed is registered and high during the first cycle in which any new stable value is visible. It is low otherwise, including when stable values are unchanged.
- Conflict is defined as (high & ~mid) | (mid & ~low), evaluated on the stable water levels.
- water_fault is registered from conflict, so it lags the stable values by one cycle.
- Counter arithmetic is unsigned. The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.

## Timing
- Reset (synchronous): s1, s2, stable, counters, sensors_changed and water_fault all go to 0. Outputs read 0 in the cycle after the reset edge.
- Reset asserted mid-debounce discards the pending count. A level still mismatching after reset release needs a full DEBOUNCE_CYCLES again.
- Latency: a raw change first sampled into s1 at edge k appears on the stable output at edge k+1+DEBOUNCE_CYCLES.
- sensors_changed rises on that same edge. water_fault updates at edge k+2+DEBOUNCE_CYCLES.
- With DEBOUNCE_CYCLES=1, a change propagates at edge k+2: the synchroniser delay only.
- A raw pulse shorter than DEBOUNCE_CYCLES cycles, measured at s2, never reaches the outputs.

## Configuration
- SENSOR_FAULT_LATCH_EN defined: water_fault is sticky.
  - It sets on any cycle where registered conflict is 1.
  - It clears only on a clear_fault edge while conflict is 0.
  - If clear_fault and conflict coincide, the flag stays 1.
  - Reset clears it.
- SENSOR_FAULT_LATCH_EN undefined: water_fault follows conflict with one cycle of lag, and clear_fault is ignored.

## Test plan
- Reset check, DEBOUNCE_CYCLES=4: assert reset for 2 cycles while all raw inputs = 1 → all outputs 0 in the cycle after each reset edge.
- Clean transition: raw_earth_humidity 0→1 sampled at edge 10 → earth_humidity = 1 and sensors_changed = 1 exactly at edge 15, sensors_changed = 0 at edge 16.
- Glitch rejection: raw_air_humidity high for 3 cycles then low → air_humidity stays 0 and sensors_changed never pulses.
- Restart rule: raw_low_temperature high for 3 cycles, low for 1, then high → output rises 4 cycles after the second rising edge's stable period begins, not earlier.
- Fault without the macro: stable high=1, mid=0, low=1 → water_fault = 1 one cycle after the stable change; raising mid to 1 clears water_fault one cycle after mid's stable change.
- Fault with SENSOR_FAULT_LATCH_EN:
  - create a conflict, then remove it → water_fault stays 1;
  - pulse clear_fault → 0 on the next edge;
  - clear_fault during an active conflict → stays 1.
